// File: rtl/debounce_sync_if.sv
// Signal bundle between the raw input source and the debounce_sync conditioner.
// The tgl_out line exists only when DEBOUNCE_TOGGLE_EN is defined.
interface debounce_sync_if;
  logic din;
  logic dout;
  logic n_dout;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;
`ifdef DEBOUNCE_TOGGLE_EN
  logic tgl_out;
`endif

  modport master (
    output din,
    input  dout, n_dout, rise_pulse, fall_pulse, busy
`ifdef DEBOUNCE_TOGGLE_EN
    , input tgl_out
`endif
  );

  modport slave (
    input  din,
    output dout, n_dout, rise_pulse, fall_pulse, busy
`ifdef DEBOUNCE_TOGGLE_EN
    , output tgl_out
`endif
  );
endinterface

// File: rtl/debounce_sync.sv
// Synchronises a bouncy single-bit input to clk, qualifies each level change with a
// stability counter, and emits a clean level plus rise/fall pulses. Define
// DEBOUNCE_TOGGLE_EN to add a push-on/push-off tgl_out output.
module debounce_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  debounce_sync_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  // Stage p0: plain flop chain, nothing between stages
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_p0 <= '0;
    else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.din};
  end

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  // Stage p1: qualification FSM with registered outputs
  state_t           state_p1;
  logic [CNT_W-1:0] cnt;
  logic             dout_p1;
  logic             n_dout_p1;
  logic             rise_p1;
  logic             fall_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1  <= STABLE_LO;
      cnt       <= '0;
      dout_p1   <= 1'b0;
      n_dout_p1 <= 1'b1;
      rise_p1   <= 1'b0;
      fall_p1   <= 1'b0;
    end else begin
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
      case (state_p1)
        STABLE_LO: begin
          if (s_p0) begin
            state_p1 <= CHK_HI;
            cnt      <= '0;
          end
        end
        CHK_HI: begin
          if (!s_p0) begin
            state_p1 <= STABLE_LO;
            cnt      <= '0;
          end else if (cnt == CNT_LAST) begin
            state_p1  <= STABLE_HI;
            dout_p1   <= 1'b1;
            n_dout_p1 <= 1'b0;
            rise_p1   <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!s_p0) begin
            state_p1 <= CHK_LO;
            cnt      <= '0;
          end
        end
        CHK_LO: begin
          if (s_p0) begin
            state_p1 <= STABLE_HI;
            cnt      <= '0;
          end else if (cnt == CNT_LAST) begin
            state_p1  <= STABLE_LO;
            dout_p1   <= 1'b0;
            n_dout_p1 <= 1'b1;
            fall_p1   <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state_p1 <= STABLE_LO;
          cnt      <= '0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_p1;
  assign bus.n_dout     = n_dout_p1;
  assign bus.rise_pulse = rise_p1;
  assign bus.fall_pulse = fall_p1;
  assign bus.busy       = (state_p1 == CHK_HI) || (state_p1 == CHK_LO);

`ifdef DEBOUNCE_TOGGLE_EN
  // Flips on the same edge that raises rise_pulse
  logic tgl_p1;

  always_ff @(posedge clk) begin
    if (!rst_n)
      tgl_p1 <= 1'b0;
    else if (state_p1 == CHK_HI && s_p0 && cnt == CNT_LAST)
      tgl_p1 <= ~tgl_p1;
  end

  assign bus.tgl_out = tgl_p1;
`else
  // No toggle output in this build.
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with SYNC_STAGES=2, STABLE_CNT=4.
// Inputs change on negedge; outputs are checked at the following negedge.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic exp_tgl = 1'b0;

  debounce_sync_if bus ();

  debounce_sync #(
    .SYNC_STAGES (2),
    .STABLE_CNT  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    int obs;
    obs = int'(dut.cnt);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic eb, input logic ed,
                         input logic er, input logic ef);
    chk({tag, ".busy"},   bus.busy,       eb);
    chk({tag, ".dout"},   bus.dout,       ed);
    chk({tag, ".n_dout"}, bus.n_dout,     ~ed);
    chk({tag, ".rise"},   bus.rise_pulse, er);
    chk({tag, ".fall"},   bus.fall_pulse, ef);
`ifdef DEBOUNCE_TOGGLE_EN
    chk({tag, ".tgl"},    bus.tgl_out,    exp_tgl);
`endif
  endtask

  // Drive din to lvl and hold: busy after edges 3..6, flip and pulse at edge 7.
  task automatic expect_trans(input string tag, input logic lvl);
    bus.din = lvl;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7 && lvl) exp_tgl = ~exp_tgl;
      chk_all($sformatf("%s.e%0d", tag, i),
              (i >= 3 && i <= 6),
              (i >= 7) ? lvl : ~lvl,
              (i == 7) && lvl,
              (i == 7) && !lvl);
    end
  endtask

  // From a stable low: din high on `hi` sampled edges (hi<=4), then low. No flip.
  task automatic glitch(input string tag, input int hi);
    for (int i = 1; i <= 10; i++) begin
      bus.din = (i <= hi);
      tick();
      chk_all($sformatf("%s.e%0d", tag, i), (i >= 3 && i <= hi + 2), 1'b0, 1'b0, 1'b0);
    end
    chk_cnt({tag, ".cnt"}, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    bus.din = 1'b1;

    // Reset held for three edges with din high
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all($sformatf("rst.e%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk_cnt("rst.cnt", 0);

    // Release with din already high: full startup latency
    rst_n = 1'b1;
    expect_trans("boot", 1'b1);

    // Clean fall then rise
    expect_trans("fall1", 1'b0);
    expect_trans("rise1", 1'b1);
    expect_trans("fall2", 1'b0);

    // Short glitches: 3 and 4 high samples are rejected
    glitch("bnc3", 3);
    glitch("bnc4", 4);

    // Five high samples qualify; the return low then qualifies a fall
    for (int i = 1; i <= 13; i++) begin
      bus.din = (i <= 5);
      tick();
      if (i == 7) exp_tgl = ~exp_tgl;
      chk_all($sformatf("q5.e%0d", i),
              (i >= 3 && i <= 6) || (i >= 8 && i <= 11),
              (i >= 7 && i <= 11),
              (i == 7),
              (i == 12));
    end

    // Reset while CHK_HI holds cnt=2 discards the qualification
    bus.din = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all($sformatf("mid.e%0d", i), (i >= 3), 1'b0, 1'b0, 1'b0);
    end
    chk_cnt("mid.cnt2", 2);
    rst_n = 1'b0;
    tick();
    exp_tgl = 1'b0;
    chk_all("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("mid.cnt0", 0);
    rst_n = 1'b1;
    expect_trans("mid.rise", 1'b1);

    // Two full press/release cycles after reset
    expect_trans("p1.fall", 1'b0);
    expect_trans("p2.rise", 1'b1);
    expect_trans("p2.fall", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
